// File: rtl/data_sram_ctrl_pkg.sv
// Shared constants for the data-memory SRAM controller: FSM state encodings
// and the default SRAM address / byte-enable widths.
package data_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    SramIdle  = 2'd0,
    SramRead  = 2'd1,
    SramWrite = 2'd2,
    SramDone  = 2'd3
  } sram_state_e;

  localparam int SramAddrWidth = 20;
  localparam int SramBeWidth   = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/data_sram_ctrl.sv
// Data-memory port responder driving an asynchronous 32-bit SRAM with programmable wait states.
// Optional one-entry read buffer enabled by defining SRAM_CTRL_RDBUF_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// SramIdle   | waiting for a request; strobes inactive
// SramRead   | ce_n/oe_n low, counting down RD_WAIT; data captured at count 1
// SramWrite  | ce_n/we_n low, counting down WR_WAIT
// SramDone   | stall released; write data still driven for hold time
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = SramAddrWidth,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ram_en_i,
  input  logic                   ram_write_en_i,
  input  logic [31:0]            ram_addr_i,
  input  logic [31:0]            ram_data_i,
  input  logic [SramBeWidth-1:0] ram_select_i,
  output logic [31:0]            ram_data_o,
  output logic                   pause_mem_o,
  output logic [ADDR_W-1:0]      sram_addr_o,
  output logic [31:0]            sram_wdata_o,
  output logic                   sram_wdata_oe_o,
  input  logic [31:0]            sram_rdata_i,
  output logic                   sram_ce_n_o,
  output logic                   sram_oe_n_o,
  output logic                   sram_we_n_o,
  output logic [SramBeWidth-1:0] sram_be_n_o
);

  localparam int CNT_W = $clog2(max_int(RD_WAIT, WR_WAIT) + 1);

  sram_state_e state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q;
  logic                   wr_q;
  logic [31:0]            wdata_q;
  logic [SramBeWidth-1:0] sel_q;
  logic [31:0]            rdata_q;

  logic                   accept;
  logic                   rd_capture;
  logic                   hit;
  logic [31:0]            hit_data;
  logic [ADDR_W-1:0]      req_word;

  assign req_word = ram_addr_i[ADDR_W+1:2];

  // Byte-offset and above-range address bits never reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SramIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    rd_capture = 1'b0;
    unique case (state_q)
      SramIdle: begin
        if (ram_en_i && !hit) begin
          accept = 1'b1;
          if (ram_write_en_i) begin
            state_d = SramWrite;
            cnt_d   = CNT_W'(WR_WAIT);
          end else begin
            state_d = SramRead;
            cnt_d   = CNT_W'(RD_WAIT);
          end
        end
      end
      SramRead: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rd_capture = 1'b1;
          state_d    = SramDone;
        end
      end
      SramWrite: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = SramDone;
        end
      end
      SramDone: state_d = SramIdle;
      default:  state_d = SramIdle;
    endcase
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  always_comb begin
    pause_mem_o     = 1'b0;
    sram_ce_n_o     = 1'b1;
    sram_oe_n_o     = 1'b1;
    sram_we_n_o     = 1'b1;
    sram_be_n_o     = '1;
    sram_wdata_oe_o = 1'b0;
    unique case (state_q)
      SramIdle: pause_mem_o = ram_en_i && !hit;
      SramRead: begin
        pause_mem_o = 1'b1;
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_be_n_o = '0;
      end
      SramWrite: begin
        pause_mem_o     = 1'b1;
        sram_ce_n_o     = 1'b0;
        sram_we_n_o     = 1'b0;
        sram_be_n_o     = ~sel_q;
        sram_wdata_oe_o = 1'b1;
      end
      SramDone: sram_wdata_oe_o = wr_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_word;
        wr_q    <= ram_write_en_i;
        wdata_q <= ram_data_i;
        sel_q   <= ram_select_i;
      end
      if (rd_capture) begin
        rdata_q <= sram_rdata_i;
      end else if (hit) begin
        rdata_q <= hit_data;
      end
    end
  end

  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign ram_data_o   = hit ? hit_data : rdata_q;

`ifdef SRAM_CTRL_RDBUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_word_q;
  logic [31:0]       buf_data_q;
  logic [31:0]       buf_merged;
  logic              buf_match;

  assign buf_match = buf_valid_q && (buf_word_q == req_word);
  assign hit       = (state_q == SramIdle) && ram_en_i && !ram_write_en_i && buf_match;
  assign hit_data  = buf_data_q;

  always_comb begin
    buf_merged = buf_data_q;
    for (int b = 0; b < SramBeWidth; b++) begin
      if (ram_select_i[b]) buf_merged[8*b +: 8] = ram_data_i[8*b +: 8];
    end
  end

  // Stores to the buffered word are merged at acceptance so later hits stay coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
    end else if (rd_capture) begin
      buf_valid_q <= 1'b1;
      buf_word_q  <= addr_q;
      buf_data_q  <= sram_rdata_i;
    end else if (accept && ram_write_en_i && buf_match) begin
      buf_data_q <= buf_merged;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl: transaction-level reference model,
// per-cycle output compare, directed literal checks plus randomized traffic.
module tb_data_sram_ctrl;

  localparam int RD = 2;
  localparam int WR = 2;
  localparam int AW = 20;
`ifdef SRAM_CTRL_RDBUF_EN
  localparam bit RDBUF = 1'b1;
`else
  localparam bit RDBUF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ram_en, ram_write_en;
  logic [31:0]   ram_addr, ram_wdata;
  logic [3:0]    ram_select;
  logic [31:0]   ram_data_o;
  logic          pause_mem_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_wdata_o;
  logic          sram_wdata_oe_o;
  logic [31:0]   sram_rdata_i;
  logic          sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [3:0]    sram_be_n_o;

  data_sram_ctrl #(.ADDR_W(AW), .RD_WAIT(RD), .WR_WAIT(WR)) dut (
    .clk(clk), .rst(rst),
    .ram_en_i(ram_en), .ram_write_en_i(ram_write_en), .ram_addr_i(ram_addr),
    .ram_data_i(ram_wdata), .ram_select_i(ram_select), .ram_data_o(ram_data_o),
    .pause_mem_o(pause_mem_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_wdata_oe_o(sram_wdata_oe_o), .sram_rdata_i(sram_rdata_i),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_be_n_o(sram_be_n_o)
  );

  always #5 clk = ~clk;

  // Board SRAM: combinational read, byte-masked write while we_n is low.
  logic [31:0] sram_mem [256] = '{4: 32'hDEAD_BEEF, default: 32'h0};
  assign sram_rdata_i = (!sram_oe_n_o && !sram_ce_n_o) ? sram_mem[sram_addr_o[7:0]] : 32'hA5A5_5A5A;
  always @(posedge clk) begin
    if (!sram_we_n_o && !sram_ce_n_o) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_be_n_o[b]) sram_mem[sram_addr_o[7:0]][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [256] = '{4: 32'hDEAD_BEEF, default: 32'h0};
  bit          buf_v;
  logic [19:0] buf_w;
  logic [31:0] buf_d;

  logic        exp_pause, exp_ce, exp_oe, exp_we, exp_wdoe;
  logic [3:0]  exp_be;
  logic [19:0] exp_addr;
  logic [31:0] exp_wdata, exp_rdata;
  bit          chk_en = 1'b0;

  int tests = 0;
  int failed = 0;
  int cnt_pause, cnt_we, cnt_wdoe, cnt_ovl;
  logic [3:0]  last_be;
  logic [19:0] last_rd_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (pause_mem_o) cnt_pause++;
    if (!sram_we_n_o) begin cnt_we++; last_be = sram_be_n_o; end
    if (!sram_oe_n_o) last_rd_addr = sram_addr_o;
    if (sram_wdata_oe_o) cnt_wdoe++;
    if (!sram_we_n_o && !sram_oe_n_o) cnt_ovl++;
    if (chk_en) begin
      chk("pause",    pause_mem_o,     exp_pause);
      chk("ce_n",     sram_ce_n_o,     exp_ce);
      chk("oe_n",     sram_oe_n_o,     exp_oe);
      chk("we_n",     sram_we_n_o,     exp_we);
      chk("be_n",     sram_be_n_o,     exp_be);
      chk("wdata_oe", sram_wdata_oe_o, exp_wdoe);
      chk("sram_addr", sram_addr_o,    exp_addr);
      chk("wdata",    sram_wdata_o,    exp_wdata);
      chk("ram_data", ram_data_o,      exp_rdata);
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    ram_write_en = 1'($urandom);
    ram_addr     = $urandom;
    ram_wdata    = $urandom;
    ram_select   = 4'($urandom);
  endtask

  task automatic idle_strobes();
    exp_ce = 1'b1; exp_oe = 1'b1; exp_we = 1'b1; exp_be = 4'hF; exp_wdoe = 1'b0;
  endtask

  task automatic model_reset();
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_pause = 1'b0;
    idle_strobes();
    buf_v = 1'b0; buf_w = '0; buf_d = '0;
  endtask

  task automatic zero_counters();
    cnt_pause = 0; cnt_we = 0; cnt_wdoe = 0; cnt_ovl = 0; last_be = 'x; last_rd_addr = 'x;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      scramble();
      ram_en = 1'b0;
      idle_strobes();
      exp_pause = 1'b0;
    end
  endtask

  // One access: request cycle, wait-state cycles, then the completion cycle.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel, input bit done_en);
    logic [19:0] w;
    int n;
    w = addr[21:2];
    next_cycle();
    ram_en = 1'b1; ram_write_en = wr; ram_addr = addr; ram_wdata = data; ram_select = sel;
    idle_strobes();
    if (RDBUF && !wr && buf_v && buf_w == w) begin
      exp_pause = 1'b0;
      exp_rdata = buf_d;
      return;
    end
    exp_pause = 1'b1;
    n = wr ? WR : RD;
    for (int p = 0; p < n; p++) begin
      next_cycle();
      scramble();
      ram_en = 1'b1;
      exp_pause = 1'b1; exp_ce = 1'b0; exp_addr = w; exp_wdata = data;
      if (wr) begin
        exp_we = 1'b0; exp_oe = 1'b1; exp_be = ~sel; exp_wdoe = 1'b1;
      end else begin
        exp_we = 1'b1; exp_oe = 1'b0; exp_be = 4'h0; exp_wdoe = 1'b0;
      end
    end
    next_cycle();
    scramble();
    ram_en = done_en;
    idle_strobes();
    exp_pause = 1'b0;
    exp_wdoe  = wr;
    if (wr) begin
      ref_mem[w[7:0]] = merge(ref_mem[w[7:0]], data, sel);
      if (buf_v && buf_w == w) buf_d = merge(buf_d, data, sel);
    end else begin
      exp_rdata = ref_mem[w[7:0]];
      buf_v = 1'b1; buf_w = w; buf_d = exp_rdata;
    end
  endtask

  function automatic logic [31:0] rand_addr(input logic [3:0] w);
    logic [31:0] a;
    a = $urandom;
    a[21:6] = '0;
    a[5:2]  = w;
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ram_en = 1'b0; ram_write_en = 1'b0; ram_addr = '0; ram_wdata = '0; ram_select = '0;
    model_reset();
    zero_counters();

    // Reset values, sampled while reset is held.
    #13;
    chk("rst_ram_data", ram_data_o, 32'h0);
    chk("rst_pause", pause_mem_o, 1'b0);
    chk("rst_addr", sram_addr_o, 20'h0);
    chk("rst_wdata", sram_wdata_o, 32'h0);
    chk("rst_wdata_oe", sram_wdata_oe_o, 1'b0);
    chk("rst_ce_n", sram_ce_n_o, 1'b1);
    chk("rst_oe_n", sram_oe_n_o, 1'b1);
    chk("rst_we_n", sram_we_n_o, 1'b1);
    chk("rst_be_n", sram_be_n_o, 4'hF);
    #10 rst = 1'b1;
    chk_en = 1'b1;
    idle(3);

    // Load of 0x10.
    zero_counters();
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
    chk("load_rdata", ram_data_o, 32'hDEAD_BEEF);
    idle(1);
    chk("load_pause_cycles", cnt_pause, 3);
    chk("load_sram_addr", last_rd_addr, 20'h4);

    // Store then an immediate load of the same word.
    zero_counters();
    do_txn(1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101, 1'b1);
    do_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
    chk("store_reload", ram_data_o, 32'h0022_0044);
    chk("store_we_cycles", cnt_we, 2);
    chk("store_be_n", last_be, 4'b1010);
    chk("store_wdoe_cycles", cnt_wdoe, 3);
    chk("we_oe_overlap", cnt_ovl, 0);
    idle(2);

    // Reset pulse during the second READ cycle.
    next_cycle();
    ram_en = 1'b1; ram_write_en = 1'b0; ram_addr = 32'h30; ram_wdata = '0; ram_select = '0;
    idle_strobes(); exp_pause = 1'b1;
    next_cycle();
    exp_ce = 1'b0; exp_oe = 1'b0; exp_be = 4'h0; exp_addr = 20'hC; exp_wdata = '0;
    next_cycle();
    chk_en = 1'b0;
    #2 rst = 1'b0; ram_en = 1'b0;
    #1;
    chk("rstmid_ce_n", sram_ce_n_o, 1'b1);
    chk("rstmid_oe_n", sram_oe_n_o, 1'b1);
    chk("rstmid_be_n", sram_be_n_o, 4'hF);
    chk("rstmid_pause", pause_mem_o, 1'b0);
    chk("rstmid_ram_data", ram_data_o, 32'h0);
    #9 rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    idle(3);

`ifdef SRAM_CTRL_RDBUF_EN
    do_txn(1'b0, 32'h0000_0010, $urandom, 4'h0, 1'b0);
    zero_counters();
    do_txn(1'b0, 32'h0000_0010, $urandom, 4'h0, 1'b0);
    chk("hit_rdata", ram_data_o, 32'hDEAD_BEEF);
    chk("hit_pause", pause_mem_o, 1'b0);
    chk("hit_ce_n", sram_ce_n_o, 1'b1);
    idle(1);
    chk("hit_pause_cycles", cnt_pause, 0);
    do_txn(1'b1, 32'h0000_0010, 32'h0000_0055, 4'b0001, 1'b0);
    idle(1);
    do_txn(1'b0, 32'h0000_0010, $urandom, 4'h0, 1'b0);
    chk("merge_hit_rdata", ram_data_o, 32'hDEAD_BE55);
    chk("merge_hit_pause", pause_mem_o, 1'b0);
    idle(1);
`endif

    // Randomized traffic over a small word range so reuse and buffer hits occur.
    for (int i = 0; i < 300; i++) begin
      bit wr;
      logic [3:0] sel;
      wr  = ($urandom_range(0, 4) < 2);
      sel = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      do_txn(wr, rand_addr(4'($urandom)), $urandom, sel, 1'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(2);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/data_sram_ctrl.md
# data_sram_ctrl

Responder for the core's data-memory port: accepts the core's single-word load/store requests and drives an external asynchronous 32-bit SRAM with programmable wait states. Raises a pause request into the pipeline controller while an access is in flight, and returns read data to the memory stage. Sits between the core top level's `ram_*` pins and the board SRAM.

## Interface
Parameters:
- `ADDR_W`, default 20: SRAM word-address width. The SRAM address is the byte address bits [ADDR_W+1:2].
- `RD_WAIT`, default 2: cycles `sram_oe_n_o` is held low per read. Minimum 1.
- `WR_WAIT`, default 2: cycles `sram_we_n_o` is held low per write. Minimum 1.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ram_en_i` in 1: access request from the core.
- `ram_write_en_i` in 1: 1 = store, 0 = load.
- `ram_addr_i` in 32: byte address. Bits [1:0] are ignored.
- `ram_data_i` in 32: store data.
- `ram_select_i` in 4: byte enables for stores, bit n = byte n.
- `ram_data_o` out 32: load data returned to the core.
- `pause_mem_o` out 1: stall request to the pipeline controller.
- `sram_addr_o` out ADDR_W: SRAM word address.
- `sram_wdata_o` out 32: SRAM write data.
- `sram_wdata_oe_o` out 1: enable for the board-level tristate data buffer.
- `sram_rdata_i` in 32: SRAM read data.
- `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o` out 1 each: active-low SRAM strobes.
- `sram_be_n_o` out 4: active-low byte enables.

## Operation
- States: IDLE, READ, WRITE, DONE. A wait counter is sized `$clog2(max(RD_WAIT,WR_WAIT)+1)`.
- IDLE with `ram_en_i`=1:
  - Latch address, write flag, data and select.
  - Load the counter with RD_WAIT or WR_WAIT.
  - Go to READ or WRITE.
- READ:
  - `ce_n`=0, `oe_n`=0, `be_n`=4'b0000.
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, capture `sram_rdata_i` into the read register, then go to DONE.
- WRITE:
  - `ce_n`=0, `we_n`=0, `be_n`=~latched select, `wdata_oe`=1.
  - Count down the same way, then go to DONE.
- DONE:
  - `pause_mem_o`=0 and `ram_data_o` holds valid load data.
  - For a write, `we_n`=1 and `ce_n`=1, with `wdata_oe` and `wdata` held one extra cycle (data hold time).
  - Always go to IDLE next. No request is accepted in DONE.
- `pause_mem_o` = (IDLE & `ram_en_i` & ~hit) | READ | WRITE. It is combinational, so the core sees the stall in the request cycle.
- The core must hold the request stable while `pause_mem_o`=1. Inputs are latched at acceptance; changes after that are ignored.
- Loads always fetch the full word. The core's memory stage extracts bytes and halfwords.
- `ram_data_o` equals the read register. It holds its last value outside DONE and hit cycles.

## Timing
- Load: accepted in cycle 0, READ in cycles 1..RD_WAIT, DONE in cycle RD_WAIT+1.
  - `pause_mem_o` is high for RD_WAIT+1 cycles.
  - The core advances at the end of DONE.
- Store: accepted in cycle 0, WRITE in cycles 1..WR_WAIT, DONE in cycle WR_WAIT+1 (data hold).
- Back-to-back requests: the earliest the next request can be accepted is the cycle after DONE.
- Reset values:
  - `ram_data_o`=0, `pause_mem_o`=0.
  - `sram_addr_o`=0, `sram_wdata_o`=0, `sram_wdata_oe_o`=0.
  - `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o` = 1; `sram_be_n_o`=4'hF.
  - State IDLE.
- Reset asserted mid-access: all strobes deassert immediately (asynchronously). The access is abandoned and no completion is signalled.
- `ram_en_i`=1 with `ram_select_i`=0 on a store: still a full WRITE sequence with `be_n`=4'hF (no bytes change).

## Configuration
- `SRAM_CTRL_RDBUF_EN` defined: a one-entry read buffer holds {valid, word address, data}.
  - Filled on every completed load.
  - A load in IDLE whose address matches a valid entry is a hit:
    - `pause_mem_o` stays 0.
    - `ram_data_o` is driven from the buffer combinationally in the same cycle.
    - The SRAM is not accessed.
  - A store to the buffered address merges its selected bytes into the buffer at acceptance.
  - Reset clears valid.
- `SRAM_CTRL_RDBUF_EN` not defined: hit is constant 0 and every load takes the full READ path.

## Structure
- Shared constants go in the common define header:
  - state encodings `SramIdle`, `SramRead`, `SramWrite`, `SramDone`;
  - `SramAddrWidth`;
  - `SramBeWidth`.
- Single module with no sub-module. The optional read buffer is inline logic under the macro.

## Test plan
- Reset held low, then released with RD_WAIT=2: every output equals its reset value; `pause_mem_o`=0 while idle.
- Load from 0x0000_0010 with the SRAM model returning 0xDEAD_BEEF (RD_WAIT=2):
  - `sram_addr_o`=4;
  - `pause_mem_o` high for exactly 3 cycles;
  - `ram_data_o`=0xDEAD_BEEF in DONE.
- Store 0x1122_3344 with select 4'b0101 to 0x20 (WR_WAIT=2):
  - `we_n` low for 2 cycles with `be_n`=4'b1010;
  - `wdata_oe` high for 3 cycles;
  - a follow-up load of 0x20 over an initial 0 returns 0x0022_0044.
- Store followed immediately by a load: the load is accepted in the cycle after the store's DONE, with no overlap of `we_n` and `oe_n`.
- `rst` pulsed low in the second READ cycle: strobes go high within the same cycle; the state is IDLE after release; no DONE occurs.
- With `SRAM_CTRL_RDBUF_EN` defined:
  - a second load of 0x10 returns 0xDEAD_BEEF with `pause_mem_o`=0 and `ce_n` staying high;
  - after a store of select 4'b0001, data 0x55 to 0x10, a reload returns 0xDEAD_BE55 as a hit.
